// File: rtl/ap_drv_pkg.sv
// ap_drv_pkg: shared state encoding and width defaults for the ap_ctrl_hs driver.
package ap_drv_pkg;
    localparam int CNT_W_DEF = 32;
    localparam int TXN_W_DEF = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} drv_state_e;
endpackage

// File: rtl/ts_fifo.sv
// ts_fifo: DEPTH x W timestamp FIFO with same-cycle push/pop and a synchronous flush.
module ts_fifo
    import ap_drv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CNT_W_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wr_data,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule

// File: rtl/ap_ctrl_hs_driver.sv
// ap_ctrl_hs_driver: issues num_txn overlapped ap_ctrl_hs transactions and reports latencies.
// Optional watchdog enabled by defining AP_DRV_WATCHDOG_EN (adds the wdog_trip port).
module ap_ctrl_hs_driver
    import ap_drv_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int TXN_W    = TXN_W_DEF,
    parameter int DEPTH    = 4,
    parameter int WDOG_CYC = 100000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [TXN_W-1:0] num_txn,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             busy,
    output logic             finish,
    output logic [TXN_W-1:0] started_cnt,
    output logic [TXN_W-1:0] done_cnt,
    output logic             lat_valid,
    output logic [CNT_W-1:0] lat_cycles,
    output logic [CNT_W-1:0] run_cycles
`ifdef AP_DRV_WATCHDOG_EN
    ,
    output logic             wdog_trip
`endif
);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    drv_state_e state, state_nxt;
    logic [TXN_W-1:0] num_lat, num_nxt, started_nxt, done_nxt;
    logic [CNT_W-1:0] ts_head;
    logic [OCC_W-1:0] occ, occ_nxt;
    logic accept, push, pop, full, empty, trip;
    assign ap_continue = 1'b1;
    assign accept      = run && state == IDLE;
    assign push        = ap_start && ap_ready && (!full || pop);
    // A done with nothing outstanding is a kernel protocol error and is dropped.
    assign pop         = ap_done && !empty && (state == ISSUE || state == DRAIN);
    assign num_nxt     = accept ? num_txn : num_lat;
    assign started_nxt = accept ? '0 : started_cnt + TXN_W'(push);
    assign done_nxt    = accept ? '0 : done_cnt + TXN_W'(pop);
    assign occ_nxt     = occ + OCC_W'(push) - OCC_W'(pop);
    ts_fifo #(.DEPTH(DEPTH), .W(CNT_W)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush   (state == DONE),
        .push    (push),
        .pop     (pop),
        .wr_data (run_cycles),
        .rd_data (ts_head),
        .full    (full),
        .empty   (empty),
        .count   (occ)
    );
`ifdef AP_DRV_WATCHDOG_EN
    logic [CNT_W-1:0] wdog_cnt;
    assign trip = busy && !(ap_ready || ap_done) && wdog_cnt == CNT_W'(WDOG_CYC - 1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdog_cnt  <= '0;
            wdog_trip <= 1'b0;
        end else begin
            wdog_cnt  <= (!busy || ap_ready || ap_done) ? '0 : wdog_cnt + CNT_W'(1);
            wdog_trip <= accept ? 1'b0 : (trip || wdog_trip);
        end
    end
`else
    assign trip = 1'b0;
`endif
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (run) state_nxt = num_txn == '0 ? DONE : ISSUE;
            ISSUE: state_nxt = started_nxt == num_nxt ? DRAIN : ISSUE;
            DRAIN: state_nxt = done_nxt == num_nxt ? DONE : DRAIN;
            DONE:  state_nxt = IDLE;
        endcase
        if (trip) state_nxt = DONE;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ap_start    <= 1'b0;
            busy        <= 1'b0;
            finish      <= 1'b0;
            num_lat     <= '0;
            started_cnt <= '0;
            done_cnt    <= '0;
            lat_valid   <= 1'b0;
            lat_cycles  <= '0;
            run_cycles  <= '0;
        end else begin
            state       <= state_nxt;
            // Decided from next-cycle occupancy so a full FIFO never sees a start.
            ap_start    <= state_nxt == ISSUE && started_nxt < num_nxt && occ_nxt < OCC_W'(DEPTH);
            busy        <= state_nxt == ISSUE || state_nxt == DRAIN;
            finish      <= state_nxt == DONE || (finish && !accept);
            num_lat     <= num_nxt;
            started_cnt <= started_nxt;
            done_cnt    <= done_nxt;
            lat_valid   <= pop;
            lat_cycles  <= pop ? run_cycles - ts_head + CNT_W'(1) : lat_cycles;
            run_cycles  <= accept ? '0 : busy ? run_cycles + CNT_W'(1) : run_cycles;
        end
    end
endmodule

// File: tb/tb_ap_ctrl_hs_driver.sv
// tb_ap_ctrl_hs_driver: directed scenarios against a small kernel model for ap_ctrl_hs_driver.
module tb_ap_ctrl_hs_driver;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic [15:0] num_txn = '0;
    logic        ap_ready = 1'b0;
    logic        ap_done = 1'b0;
    logic        ap_start, ap_continue, busy, finish, lat_valid;
    logic [15:0] started_cnt, done_cnt;
    logic [31:0] lat_cycles, run_cycles;
`ifdef AP_DRV_WATCHDOG_EN
    logic        wdog_trip;
`endif
    int n_chk = 0;
    int n_fail = 0;

    ap_ctrl_hs_driver #(.WDOG_CYC(50)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .num_txn     (num_txn),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_continue (ap_continue),
        .busy        (busy),
        .finish      (finish),
        .started_cnt (started_cnt),
        .done_cnt    (done_cnt),
        .lat_valid   (lat_valid),
        .lat_cycles  (lat_cycles),
        .run_cycles  (run_cycles)
`ifdef AP_DRV_WATCHDOG_EN
        ,
        .wdog_trip   (wdog_trip)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic pulse_run(input logic [15:0] n);
        run = 1'b1;
        num_txn = n;
        @(negedge clock);
        run = 1'b0;
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        @(negedge clock);
        n_chk++; if (ap_start !== 1'b0) begin n_fail++; $display("FAIL reset_ap_start: got %b want 0", ap_start); end
        n_chk++; if (busy !== 1'b0 || finish !== 1'b0) begin n_fail++; $display("FAIL reset_busy_finish: got %b%b want 00", busy, finish); end
        n_chk++; if (started_cnt !== 16'd0 || done_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", started_cnt, done_cnt); end
        n_chk++; if (lat_valid !== 1'b0 || lat_cycles !== 32'd0 || run_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_lat: got %b %0d %0d want 0 0 0", lat_valid, lat_cycles, run_cycles); end
        n_chk++; if (ap_continue !== 1'b1) begin n_fail++; $display("FAIL reset_ap_continue: got %b want 1", ap_continue); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_zero;
        int starts;
        n_chk++; if (finish !== 1'b0) begin n_fail++; $display("FAIL zero_pre_finish: got %b want 0", finish); end
        pulse_run(16'd0);
        n_chk++; if (finish !== 1'b1) begin n_fail++; $display("FAIL zero_finish: got %b want 1", finish); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b want 0", busy); end
        starts = 0;
        for (int k = 0; k < 5; k++) begin
            if (ap_start) starts++;
            @(negedge clock);
        end
        n_chk++; if (starts !== 0 || finish !== 1'b1) begin n_fail++; $display("FAIL zero_no_start: got starts=%0d finish=%b want 0 1", starts, finish); end
    endtask

    task automatic test_single;
        int lats, fin_k;
        logic [31:0] lat_v;
        logic s0, s3;
        lats = 0; fin_k = -1; lat_v = '0; s0 = 1'b0; s3 = 1'b1;
        pulse_run(16'd1);
        for (int k = 0; k < 40; k++) begin
            if (lat_valid) begin lats++; lat_v = lat_cycles; end
            if (finish) begin fin_k = k; break; end
            if (k == 0) s0 = ap_start;
            if (k == 3) s3 = ap_start;
            ap_ready = (k == 2);
            ap_done = (k == 12);
            @(negedge clock);
        end
        ap_ready = 1'b0;
        ap_done = 1'b0;
        n_chk++; if (s0 !== 1'b1) begin n_fail++; $display("FAIL single_start_c0: got %b want 1", s0); end
        n_chk++; if (s3 !== 1'b0) begin n_fail++; $display("FAIL single_start_c3: got %b want 0", s3); end
        n_chk++; if (fin_k !== 13) begin n_fail++; $display("FAIL single_finish_cycle: got %0d want 13", fin_k); end
        n_chk++; if (lats !== 1 || lat_v !== 32'd11) begin n_fail++; $display("FAIL single_latency: got %0d strobes lat=%0d want 1 lat=11", lats, lat_v); end
        n_chk++; if (done_cnt !== 16'd1 || started_cnt !== 16'd1) begin n_fail++; $display("FAIL single_counts: got %0d/%0d want 1/1", started_cnt, done_cnt); end
        n_chk++; if (busy !== 1'b0 || run_cycles !== 32'd13) begin n_fail++; $display("FAIL single_busy_runcyc: got %b %0d want 0 13", busy, run_cycles); end
        @(negedge clock);
        @(negedge clock);
        n_chk++; if (finish !== 1'b1 || lat_valid !== 1'b0 || run_cycles !== 32'd13) begin n_fail++; $display("FAIL single_sticky: got fin=%b lv=%b rc=%0d want 1 0 13", finish, lat_valid, run_cycles); end
    endtask

    // Kernel always ready; each accepted start completes dly cycles later.
    task automatic test_stream(input string name, input int num, input int dly, input int exp_lat,
                               input int exp_max, input bit poke);
        int starts, dones, out_max, lats, bad_lat, fin_k, last_done;
        int due[$];
        starts = 0; dones = 0; out_max = 0; lats = 0; bad_lat = 0; fin_k = -1; last_done = -1;
        ap_ready = 1'b1;
        pulse_run(16'(num));
        for (int k = 0; k < 200; k++) begin
            if (lat_valid) begin lats++; if (lat_cycles !== 32'(exp_lat)) bad_lat++; end
            if (finish) begin fin_k = k; break; end
            n_chk++;
            if (ap_start !== (starts < num && starts - dones < 4)) begin
                n_fail++;
                $display("FAIL %s_ap_start c%0d: got %b want %b", name, k, ap_start, (starts < num && starts - dones < 4));
            end
            run = poke && k == 3;
            num_txn = 16'd3;
            ap_done = due.size() > 0 && due[0] == k;
            if (ap_done) begin void'(due.pop_front()); dones++; last_done = k; end
            if (ap_start) begin due.push_back(k + dly); starts++; end
            if (starts - dones > out_max) out_max = starts - dones;
            @(negedge clock);
        end
        ap_ready = 1'b0;
        ap_done = 1'b0;
        run = 1'b0;
        n_chk++; if (fin_k !== last_done + 1) begin n_fail++; $display("FAIL %s_finish_cycle: got %0d want %0d", name, fin_k, last_done + 1); end
        n_chk++; if (lats !== num || bad_lat !== 0) begin n_fail++; $display("FAIL %s_latencies: got %0d strobes %0d wrong want %0d strobes all %0d", name, lats, bad_lat, num, exp_lat); end
        n_chk++; if (out_max !== exp_max) begin n_fail++; $display("FAIL %s_occupancy: got %0d want %0d", name, out_max, exp_max); end
        n_chk++; if (started_cnt !== 16'(num) || done_cnt !== 16'(num)) begin n_fail++; $display("FAIL %s_counts: got %0d/%0d want %0d/%0d", name, started_cnt, done_cnt, num, num); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b want 0", name, busy); end
        @(negedge clock);
    endtask

    task automatic test_overlap;
        test_stream("overlap", 8, 6, 7, 4, 1'b1);
    endtask

    task automatic test_full_pushpop;
        test_stream("pushpop", 6, 4, 5, 4, 1'b0);
    endtask

    task automatic test_reset_mid;
        ap_ready = 1'b1;
        pulse_run(16'd5);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        ap_ready = 1'b0;
        n_chk++; if (started_cnt !== 16'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre_reset: got started=%0d busy=%b want 3 1", started_cnt, busy); end
        reset = 1'b1;
        #1;
        n_chk++; if (ap_start !== 1'b0 || busy !== 1'b0 || finish !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags: got %b%b%b want 000", ap_start, busy, finish); end
        n_chk++; if (started_cnt !== 16'd0 || done_cnt !== 16'd0 || run_cycles !== 32'd0 || lat_cycles !== 32'd0) begin n_fail++; $display("FAIL mid_reset_counts: got %0d %0d %0d %0d want 0 0 0 0", started_cnt, done_cnt, run_cycles, lat_cycles); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        test_stream("after_reset", 2, 3, 4, 2, 1'b0);
    endtask

`ifdef AP_DRV_WATCHDOG_EN
    task automatic test_watchdog;
        int fin_k;
        fin_k = -1;
        pulse_run(16'd2);
        for (int k = 0; k < 100; k++) begin
            if (finish) begin fin_k = k; break; end
            @(negedge clock);
        end
        n_chk++; if (fin_k !== 50) begin n_fail++; $display("FAIL wdog_finish_cycle: got %0d want 50", fin_k); end
        n_chk++; if (wdog_trip !== 1'b1 || busy !== 1'b0 || started_cnt !== 16'd0) begin n_fail++; $display("FAIL wdog_state: got trip=%b busy=%b started=%0d want 1 0 0", wdog_trip, busy, started_cnt); end
        @(negedge clock);
    endtask
`endif

    initial begin
        test_reset;
        test_zero;
        test_single;
        test_overlap;
        test_full_pushpop;
        test_reset_mid;
`ifdef AP_DRV_WATCHDOG_EN
        test_watchdog;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
